// File: rtl/usb_cmd_pkg.sv
// Shared constants and state encoding for the USB command to AXI-Lite bridge.
// Timeout support is enabled with the USB_CMD_TIMEOUT_EN macro.
package usb_cmd_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h01;
  localparam logic [7:0] OP_READ    = 8'h02;
  localparam logic [7:0] ST_BADOP   = 8'hFF;
  localparam logic [7:0] ST_TIMEOUT = 8'h80;

  // Longest response: status byte followed by 32-bit read data.
  localparam int RESP_BYTES = 5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR0,
    S_ADDR1,
    S_DATA,
    S_WADDR,
    S_WRESP,
    S_RADDR,
    S_RDATA,
    S_RESP
  } state_t;

  function automatic logic [7:0] status_byte(input logic [1:0] resp);
    return {6'b0, resp};
  endfunction

endpackage

// File: rtl/usb_cmd_tx_serializer.sv
// Sends a 1..5 byte response (byte 0 first) over a valid/ready byte stream.
// A start pulse loads the word; done pulses one cycle after the last byte is taken.
module usb_cmd_tx_serializer
  import usb_cmd_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*RESP_BYTES-1:0] data,
  input  logic [2:0]              len,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    done
);

  logic [8*RESP_BYTES-1:0] word_reg;
  logic [2:0]              len_reg;
  logic [2:0]              cnt_reg;
  logic [2:0]              cnt_next;
  logic [7:0]              tx_data_reg;
  logic                    tx_valid_reg;
  logic                    done_reg;
  logic [7:0]              byte_arr [8];

  // Byte lanes beyond the response width read as zero so the 3-bit index stays in range.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bytes
      if (gi < RESP_BYTES) begin : g_used
        assign byte_arr[gi] = word_reg[8*gi +: 8];
      end else begin : g_pad
        assign byte_arr[gi] = 8'h00;
      end
    end
  endgenerate

  assign cnt_next = cnt_reg + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_reg     <= '0;
      len_reg      <= '0;
      cnt_reg      <= '0;
      tx_data_reg  <= '0;
      tx_valid_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start && !tx_valid_reg) begin
        word_reg     <= data;
        len_reg      <= len;
        cnt_reg      <= '0;
        tx_data_reg  <= data[7:0];
        tx_valid_reg <= 1'b1;
      end else if (tx_valid_reg && tx_ready) begin
        if (cnt_reg == len_reg - 3'd1) begin
          tx_valid_reg <= 1'b0;
          done_reg     <= 1'b1;
        end else begin
          cnt_reg     <= cnt_next;
          tx_data_reg <= byte_arr[cnt_next];
        end
      end
    end
  end

  assign tx_data  = tx_data_reg;
  assign tx_valid = tx_valid_reg;
  assign done     = done_reg;

endmodule

// File: rtl/usb_cmd_axil_master.sv
// Parses write/read command packets from a byte stream, runs one AXI-Lite transfer,
// and returns a status (plus read data). USB_CMD_TIMEOUT_EN adds a slave-handshake timeout.
module usb_cmd_axil_master
  import usb_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [14:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [14:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  state_t                  state_reg;
  logic                    op_read_reg;
  logic [14:0]             addr_reg;
  logic [31:0]             wdata_reg;
  logic [1:0]              dcnt_reg;
  logic                    awvalid_reg;
  logic                    wvalid_reg;
  logic                    bready_reg;
  logic                    arvalid_reg;
  logic                    rready_reg;
  logic [8*RESP_BYTES-1:0] resp_reg;
  logic [2:0]              resp_len_reg;
  logic                    start_reg;
  logic                    ser_done;

  logic rx_fire;
  logic waddr_done;
  logic wresp_done;
  logic raddr_done;
  logic rdata_done;
  logic tmo_hit;

  assign rx_ready = (state_reg == S_IDLE) || (state_reg == S_ADDR0) ||
                    (state_reg == S_ADDR1) || (state_reg == S_DATA);
  assign rx_fire  = rx_valid && rx_ready;

  // WADDR is complete when neither channel still has an outstanding, unaccepted valid.
  assign waddr_done = !(awvalid_reg && !m_axi_awready) && !(wvalid_reg && !m_axi_wready);
  assign wresp_done = bready_reg && m_axi_bvalid;
  assign raddr_done = arvalid_reg && m_axi_arready;
  assign rdata_done = rready_reg && m_axi_rvalid;

`ifdef USB_CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic        axi_state;
  logic        axi_adv;
  logic [15:0] tmo_cnt_reg;

  assign axi_state = (state_reg == S_WADDR) || (state_reg == S_WRESP) ||
                     (state_reg == S_RADDR) || (state_reg == S_RDATA);
  assign axi_adv   = ((state_reg == S_WADDR) && waddr_done) ||
                     ((state_reg == S_WRESP) && wresp_done) ||
                     ((state_reg == S_RADDR) && raddr_done) ||
                     ((state_reg == S_RDATA) && rdata_done);

  // Cleared outside the AXI states and on every AXI-state advance, so each state starts at 0.
  always_ff @(posedge clk) begin
    if (rst || !axi_state || axi_adv) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
    end
  end

  // A handshake completing in the final cycle still wins over the timeout.
  assign tmo_hit = axi_state && !axi_adv && (tmo_cnt_reg == TMO_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      op_read_reg  <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      dcnt_reg     <= '0;
      awvalid_reg  <= 1'b0;
      wvalid_reg   <= 1'b0;
      bready_reg   <= 1'b0;
      arvalid_reg  <= 1'b0;
      rready_reg   <= 1'b0;
      resp_reg     <= '0;
      resp_len_reg <= '0;
      start_reg    <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      if (tmo_hit) begin
        awvalid_reg  <= 1'b0;
        wvalid_reg   <= 1'b0;
        bready_reg   <= 1'b0;
        arvalid_reg  <= 1'b0;
        rready_reg   <= 1'b0;
        resp_reg     <= {32'h0, ST_TIMEOUT};
        resp_len_reg <= op_read_reg ? 3'd5 : 3'd1;
        start_reg    <= 1'b1;
        state_reg    <= S_RESP;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (rx_fire) begin
              if (rx_data == OP_WRITE || rx_data == OP_READ) begin
                op_read_reg <= (rx_data == OP_READ);
                state_reg   <= S_ADDR0;
              end else begin
                resp_reg     <= {32'h0, ST_BADOP};
                resp_len_reg <= 3'd1;
                start_reg    <= 1'b1;
                state_reg    <= S_RESP;
              end
            end
          end
          S_ADDR0: begin
            if (rx_fire) begin
              addr_reg[7:0] <= rx_data;
              state_reg     <= S_ADDR1;
            end
          end
          S_ADDR1: begin
            if (rx_fire) begin
              addr_reg[14:8] <= rx_data[6:0];
              if (op_read_reg) begin
                arvalid_reg <= 1'b1;
                state_reg   <= S_RADDR;
              end else begin
                dcnt_reg  <= '0;
                state_reg <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (rx_fire) begin
              wdata_reg[8*dcnt_reg +: 8] <= rx_data;
              dcnt_reg <= dcnt_reg + 2'd1;
              if (dcnt_reg == 2'd3) begin
                awvalid_reg <= 1'b1;
                wvalid_reg  <= 1'b1;
                state_reg   <= S_WADDR;
              end
            end
          end
          S_WADDR: begin
            if (m_axi_awready) awvalid_reg <= 1'b0;
            if (m_axi_wready)  wvalid_reg  <= 1'b0;
            if (waddr_done) begin
              bready_reg <= 1'b1;
              state_reg  <= S_WRESP;
            end
          end
          S_WRESP: begin
            if (wresp_done) begin
              bready_reg   <= 1'b0;
              resp_reg     <= {32'h0, status_byte(m_axi_bresp)};
              resp_len_reg <= 3'd1;
              start_reg    <= 1'b1;
              state_reg    <= S_RESP;
            end
          end
          S_RADDR: begin
            if (raddr_done) begin
              arvalid_reg <= 1'b0;
              rready_reg  <= 1'b1;
              state_reg   <= S_RDATA;
            end
          end
          S_RDATA: begin
            if (rdata_done) begin
              rready_reg   <= 1'b0;
              resp_reg     <= {m_axi_rdata, status_byte(m_axi_rresp)};
              resp_len_reg <= 3'd5;
              start_reg    <= 1'b1;
              state_reg    <= S_RESP;
            end
          end
          S_RESP: begin
            if (ser_done) state_reg <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

  usb_cmd_tx_serializer u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (start_reg),
    .data     (resp_reg),
    .len      (resp_len_reg),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .done     (ser_done)
  );

  assign m_axi_awaddr  = addr_reg;
  assign m_axi_araddr  = addr_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_bready  = bready_reg;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = rready_reg;

endmodule

// File: tb/tb_usb_cmd_axil_master.sv
// Scoreboard bench for usb_cmd_axil_master: directed packets, AXI-Lite slave model,
// monitor that pops expected tx bytes and AXI addresses/data as the DUT presents them.
module tb_usb_cmd_axil_master;

`ifdef USB_CMD_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 65535;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [14:0] m_axi_awaddr;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;
  logic [14:0] m_axi_araddr;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rvalid;
  logic        m_axi_rready;

  usb_cmd_axil_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
    .m_axi_rready(m_axi_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Scoreboard queues
  logic [7:0]  exp_tx [$];
  logic [14:0] exp_aw [$];
  logic [31:0] exp_w  [$];
  logic [14:0] exp_ar [$];

  // Slave configuration
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
  logic [31:0] rdata_val = 32'h0;
  logic        tx_stall = 1'b0;
  logic        slave_flush = 1'b0;

  // Monitor statistics
  int aw_hi = 0, w_hi = 0, ar_hi = 0, b_cnt = 0, valid_cyc = 0, overlap_cnt = 0;

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end else begin
      $display("ok   %s = %0h", name, got);
    end
  endtask

  // AXI-Lite slave model: readies after a programmable number of valid cycles,
  // B/R responses a programmable number of cycles after the request handshake.
  int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_wait = -1, r_wait = -1;
  logic aw_got = 0, w_got = 0, b_fire = 0, r_fire = 0;
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
    m_axi_bvalid = 0; m_axi_bresp = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
    tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (slave_flush) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_arready = 0;
        m_axi_bvalid = 0; m_axi_rvalid = 0;
        b_wait = -1; r_wait = -1; aw_got = 0; w_got = 0; b_fire = 0; r_fire = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
      end else begin
        if (b_fire) m_axi_bvalid = 0;
        if (r_fire) m_axi_rvalid = 0;
        if (m_axi_awvalid) begin m_axi_awready = (aw_cnt == aw_delay); aw_cnt++; end
        else begin m_axi_awready = 0; aw_cnt = 0; end
        if (m_axi_wvalid) begin m_axi_wready = (w_cnt == w_delay); w_cnt++; end
        else begin m_axi_wready = 0; w_cnt = 0; end
        if (m_axi_arvalid) begin m_axi_arready = (ar_cnt == ar_delay); ar_cnt++; end
        else begin m_axi_arready = 0; ar_cnt = 0; end
        if (b_wait > 0) b_wait--;
        if (b_wait == 0) begin m_axi_bvalid = 1; m_axi_bresp = bresp_val; b_wait = -1; end
        if (r_wait > 0) r_wait--;
        if (r_wait == 0) begin
          m_axi_rvalid = 1; m_axi_rdata = rdata_val; m_axi_rresp = rresp_val; r_wait = -1;
        end
        if (m_axi_awvalid && m_axi_awready) aw_got = 1;
        if (m_axi_wvalid && m_axi_wready) w_got = 1;
        if (aw_got && w_got) begin b_wait = b_delay + 1; aw_got = 0; w_got = 0; end
        if (m_axi_arvalid && m_axi_arready) r_wait = r_delay + 1;
        b_fire = m_axi_bvalid && m_axi_bready;
        r_fire = m_axi_rvalid && m_axi_rready;
      end
      tx_ready = tx_stall ? ~tx_ready : 1'b1;
    end
  end

  // Monitor: samples mid-cycle after the slave has settled its inputs.
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h0;
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (rx_ready && tx_valid) overlap_cnt++;
        if (hold_prev && tx_valid) chk("tx_hold_stable", tx_data, data_prev);
        hold_prev = tx_valid && !tx_ready;
        data_prev = tx_data;
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected got=%0h exp=none", tx_data);
          end else begin
            chk("tx_byte", tx_data, exp_tx.pop_front());
          end
        end
        if (m_axi_awvalid || m_axi_wvalid || m_axi_arvalid) valid_cyc++;
        if (m_axi_awvalid) aw_hi++;
        if (m_axi_wvalid) w_hi++;
        if (m_axi_arvalid) ar_hi++;
        if (m_axi_bvalid && m_axi_bready) b_cnt++;
        if (m_axi_awvalid && m_axi_awready) begin
          if (exp_aw.size() == 0) begin
            checks++; errors++;
            $display("FAIL aw_unexpected got=%0h exp=none", m_axi_awaddr);
          end else chk("awaddr", m_axi_awaddr, exp_aw.pop_front());
        end
        if (m_axi_wvalid && m_axi_wready) begin
          if (exp_w.size() == 0) begin
            checks++; errors++;
            $display("FAIL w_unexpected got=%0h exp=none", m_axi_wdata);
          end else begin
            chk("wdata", m_axi_wdata, exp_w.pop_front());
            chk("wstrb", m_axi_wstrb, 4'hF);
          end
        end
        if (m_axi_arvalid && m_axi_arready) begin
          if (exp_ar.size() == 0) begin
            checks++; errors++;
            $display("FAIL ar_unexpected got=%0h exp=none", m_axi_araddr);
          end else chk("araddr", m_axi_araddr, exp_ar.pop_front());
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    #1;
    while (!rx_ready && n < 200) begin @(negedge clk); #1; n++; end
    if (!rx_ready) chk("rx_accept_timeout", 40'(rx_ready), 40'd1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(negedge clk); #3;
    while ((exp_tx.size() != 0 || tx_valid || !rx_ready) && n < 3000) begin
      @(negedge clk); #3; n++;
    end
    chk({name, "_left"}, 40'(exp_tx.size() + exp_aw.size() + exp_w.size() + exp_ar.size()), 40'd0);
  endtask

  task automatic run_write(input string name, input logic [7:0] lo, input logic [7:0] hi,
                           input logic [31:0] d, input logic [14:0] exp_addr,
                           input logic [7:0] exp_st);
    exp_aw.push_back(exp_addr);
    exp_w.push_back(d);
    exp_tx.push_back(exp_st);
    send_byte(8'h01); send_byte(lo); send_byte(hi);
    send_byte(d[7:0]); send_byte(d[15:8]); send_byte(d[23:16]); send_byte(d[31:24]);
    drain(name);
  endtask

  task automatic run_read(input string name, input logic [7:0] lo, input logic [7:0] hi,
                          input logic [14:0] exp_addr, input logic [31:0] rd,
                          input logic [1:0] rr);
    rdata_val = rd;
    rresp_val = rr;
    exp_ar.push_back(exp_addr);
    exp_tx.push_back({6'b0, rr});
    exp_tx.push_back(rd[7:0]);
    exp_tx.push_back(rd[15:8]);
    exp_tx.push_back(rd[23:16]);
    exp_tx.push_back(rd[31:24]);
    send_byte(8'h02); send_byte(lo); send_byte(hi);
    drain(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rx_ready", rx_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_arvalid", m_axi_arvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_rready", m_axi_rready, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    chk("rst_wdata", m_axi_wdata, 0);
    rst = 1'b0;

    // Basic write, slave OKAY
    run_write("wr_basic", 8'h84, 8'h00, 32'hDEADBEEF, 15'h0084, 8'h00);

    // Read with SLVERR and a stalling tx consumer
    tx_stall = 1'b1;
    r_delay = 2;
    run_read("rd_basic", 8'h10, 8'h00, 15'h0010, 32'h12345678, 2'd2);
    tx_stall = 1'b0;
    r_delay = 0;

    // awready late by 5 cycles, wready immediate; bresp SLVERR; address bit 15 ignored
    aw_delay = 5; w_delay = 0; bresp_val = 2'd2;
    aw_hi = 0; w_hi = 0; b_cnt = 0;
    run_write("wr_aw_late", 8'h34, 8'hF2, 32'h0BADF00D, 15'h7234, 8'h02);
    chk("aw_valid_cycles", 40'(aw_hi), 40'd6);
    chk("w_valid_cycles", 40'(w_hi), 40'd1);
    chk("b_accepted", 40'(b_cnt), 40'd1);

    // wready late by 3 cycles, awready immediate, B delayed
    aw_delay = 0; w_delay = 3; b_delay = 4; bresp_val = 2'd0;
    aw_hi = 0; w_hi = 0; b_cnt = 0;
    run_write("wr_w_late", 8'hFF, 8'h7F, 32'h01020304, 15'h7FFF, 8'h00);
    chk("aw_valid_cycles2", 40'(aw_hi), 40'd1);
    chk("w_valid_cycles2", 40'(w_hi), 40'd4);
    chk("b_accepted2", 40'(b_cnt), 40'd1);
    w_delay = 0; b_delay = 0;

    // Unknown opcode, then a normal read
    valid_cyc = 0;
    exp_tx.push_back(8'hFF);
    send_byte(8'h07);
    drain("bad_op");
    chk("bad_op_axi_valids", 40'(valid_cyc), 40'd0);
    ar_delay = 2;
    run_read("rd_after_bad", 8'h00, 8'h01, 15'h0100, 32'hCAFEF00D, 2'd0);
    ar_delay = 0;

    // Reset while waiting for read data; rvalid then arrives
    r_delay = 10;
    exp_ar.push_back(15'h0020);
    send_byte(8'h02); send_byte(8'h20); send_byte(8'h00);
    n = 0;
    @(negedge clk); #1;
    while (!m_axi_rready && n < 100) begin @(negedge clk); #1; n++; end
    chk("rdata_state_reached", m_axi_rready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    #1;
    chk("rst_mid_rx_ready", rx_ready, 1);
    chk("rst_mid_tx_valid", tx_valid, 0);
    chk("rst_mid_rready", m_axi_rready, 0);
    chk("rst_mid_arvalid", m_axi_arvalid, 0);
    @(posedge clk); #1;
    slave_flush = 1'b1;
    @(negedge clk); #1;
    slave_flush = 1'b0;
    r_delay = 0;

    // Partial write packet discarded by reset, then a clean read
    send_byte(8'h01); send_byte(8'h84); send_byte(8'h00); send_byte(8'hEF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    run_read("rd_after_partial", 8'h30, 8'h00, 15'h0030, 32'hA5A50001, 2'd0);

`ifdef USB_CMD_TIMEOUT_EN
    // Read with arready never asserted times out
    ar_delay = 1000;
    ar_hi = 0;
    exp_tx.push_back(8'h80);
    for (int i = 0; i < 4; i++) exp_tx.push_back(8'h00);
    send_byte(8'h02); send_byte(8'h20); send_byte(8'h00);
    drain("rd_timeout");
    chk("ar_valid_cycles_timeout", 40'(ar_hi), 40'd16);
    ar_delay = 0;
`endif

    repeat (4) @(negedge clk);
    chk("rx_ready_tx_valid_overlap", 40'(overlap_cnt), 40'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_cmd_axil_master.md
USB_CMD_AXIL_MASTER -- requirements
Module: usb_cmd_axil_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum number of cycles to wait for a slave handshake (used only with USB_CMD_TIMEOUT_EN).
REQ-002 SHALL use one clock and synchronous active-high reset; ports: clk, in, 1, clock; rst, in, 1, synchronous active-high reset.
REQ-003 Command byte stream ports: rx_data, in, 8, command byte; rx_valid, in, 1, byte present; rx_ready, out, 1, byte accepted.
REQ-004 Response byte stream ports: tx_data, out, 8, response byte; tx_valid, out, 1, byte present; tx_ready, in, 1, byte taken.
REQ-005 AXI-Lite write-address ports: m_axi_awaddr, out, 15; m_axi_awvalid, out, 1; m_axi_awready, in, 1.
REQ-006 AXI-Lite write-data ports: m_axi_wdata, out, 32; m_axi_wstrb, out, 4; m_axi_wvalid, out, 1; m_axi_wready, in, 1.
REQ-007 AXI-Lite write-response ports: m_axi_bresp, in, 2; m_axi_bvalid, in, 1; m_axi_bready, out, 1.
REQ-008 AXI-Lite read-address ports: m_axi_araddr, out, 15; m_axi_arvalid, out, 1; m_axi_arready, in, 1.
REQ-009 AXI-Lite read-data ports: m_axi_rdata, in, 32; m_axi_rresp, in, 2; m_axi_rvalid, in, 1; m_axi_rready, out, 1.

Function
REQ-010 SHALL parse packets: opcode byte (0x01 write, 0x02 read), then address low byte, then address high byte (bit 7 of the high byte ignored), then, for write only, 4 data bytes little-endian.
REQ-011 SHALL accept a byte only on rx_valid && rx_ready; rx_ready SHALL be high only in the IDLE, ADDR0, ADDR1 and DATA states.
REQ-012 SHALL implement states IDLE -> ADDR0 -> ADDR1 -> (write: DATA x4 -> WADDR -> WRESP) / (read: RADDR -> RDATA) -> RESP -> IDLE.
REQ-013 In WADDR, SHALL assert awvalid and wvalid together; each SHALL drop independently the cycle after its own handshake; SHALL leave WADDR only once both handshakes have completed, including the case where both occur in the same cycle.
REQ-014 m_axi_wstrb SHALL be 4'hF for every write; awaddr and araddr SHALL hold the captured address stably while valid is asserted.
REQ-015 In WRESP, SHALL hold bready high and capture bresp on bvalid.
REQ-016 In RADDR, SHALL hold arvalid until arready. In RDATA, SHALL hold rready high and capture rdata and rresp on rvalid.
REQ-017 Response for a write SHALL be 1 byte: status = {6'b0, bresp}.
REQ-018 Response for a read SHALL be 5 bytes: status = {6'b0, rresp}, then rdata little-endian.
REQ-019 Each tx byte SHALL be held stable until tx_ready; a 3-bit byte counter SHALL select the byte being sent.
REQ-020 An unknown opcode SHALL be consumed and SHALL produce a single status byte 0xFF; no AXI activity SHALL occur.
REQ-021 Valid-to-ready latency SHALL be 0 (a handshake may complete in the same cycle as valid asserts); the next AXI phase SHALL start the cycle after the state transition.
REQ-022 tx_valid and rx_ready SHALL never be high in the same cycle.

Reset
REQ-023 On rst, SHALL enter IDLE next cycle and drive every valid/ready output low, except rx_ready, which SHALL be high in IDLE.
REQ-024 On rst, tx_data, addresses, wdata and the counters SHALL reset to 0.
REQ-025 Reset mid-transaction SHALL abandon the transaction with no response byte emitted; a partial packet SHALL be discarded.

Configuration
REQ-026 Macro USB_CMD_TIMEOUT_EN defined: a 16-bit counter SHALL count cycles in the WADDR/WRESP/RADDR/RDATA states and reset on each state entry.
REQ-027 With USB_CMD_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the block SHALL drop all AXI valid/ready outputs, send status 0x80 (reads: 0x80 followed by 4 bytes of 0x00) and return to IDLE.
REQ-028 Macro USB_CMD_TIMEOUT_EN undefined: the counter SHALL be absent and the block SHALL wait indefinitely.

Structure
REQ-029 The shared package usb_cmd_pkg SHALL hold the opcode constants (OP_WRITE=8'h01, OP_READ=8'h02), the status constants (ST_BADOP=8'hFF, ST_TIMEOUT=8'h80) and the state encoding.
REQ-030 A single sub-module, usb_cmd_tx_serializer (5-byte shift/select plus tx handshake), is natural; all other logic SHALL be flat.

Verification
REQ-031 Write 01 84 00 EF BE AD DE, slave OKAY -> awaddr=0x0084, wdata=0xDEADBEEF, wstrb=F; tx byte 0x00.
REQ-032 Read 02 10 00, slave returns rdata=0x12345678, rresp=2 -> tx bytes 02 78 56 34 12 in order.
REQ-033 Write with awready delayed 5 cycles and wready immediate -> wvalid drops after 1 cycle and awvalid is held 6 cycles; exactly one B accepted.
REQ-034 Opcode 0x07 -> tx 0xFF, no AXI valid asserted; the next valid read then completes normally.
REQ-035 rst asserted during RDATA, rvalid then arrives -> no tx byte emitted, block in IDLE, rx_ready=1.
REQ-036 With USB_CMD_TIMEOUT_EN defined and TIMEOUT_CYCLES=16, a read with arready tied 0 -> arvalid drops after 16 cycles; tx bytes 80 00 00 00 00.
